vga_ram_port_arbiter: RTL
=========================

Name: vga_ram_port_arbiter

Overview:
Shares the single read/write port B of the cpu_top RAM between two requesters.
- VGA fetch path: the position loader plus sprite pixel fetches. It is real-time, never stalled, and gets absolute priority.
- Host requester: a CPU-side or debug agent that writes position and sprite words and reads them back.
- Host writes are posted into a small write buffer and drained only in cycles the VGA path leaves idle. Host reads are ordered behind buffered writes.

Parameters:
ADDR_WIDTH, 16, RAM word address width.
DATA_WIDTH, 16, RAM word width.
WBUF_DEPTH, 4, write-buffer entries; power of two, at least 2.
WBUF_AW, 2, log2(WBUF_DEPTH).

Ports:
pix_clk  in  1  single clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
vga_req  in  1  VGA path needs the RAM this cycle.
vga_addr  in  ADDR_WIDTH  VGA read address.
vga_q  out  DATA_WIDTH  equals ram_q_b; valid one cycle after vga_req.
host_req  in  1  host request valid.
host_we  in  1  1 = write, 0 = read.
host_addr  in  ADDR_WIDTH  host address.
host_wdata  in  DATA_WIDTH  host write data.
host_ready  out  1  request accepted this cycle when host_req && host_ready.
host_rvalid  out  1  one-cycle read-return strobe.
host_rdata  out  DATA_WIDTH  read data; valid while host_rvalid is high.
ram_addr_b  out  ADDR_WIDTH  RAM port B address.
ram_we_b  out  1  RAM port B write enable.
ram_d_b  out  DATA_WIDTH  RAM port B write data.
ram_q_b  in  DATA_WIDTH  RAM port B read data; synchronous, 1-cycle latency.

Behaviour:
- RAM port drive (ram_addr_b, ram_we_b, ram_d_b) is a combinational mux of the current grant. Priority, highest first:
  - reset asserted: addr 0, we 0.
  - vga_req: vga_addr, we 0.
  - write buffer non-empty: head entry, we 1, buffer pops.
  - state RD_PEND: pending read address, we 0 (read issue).
  - otherwise: addr 0, we 0.
- Write buffer: circular FIFO of {addr, data}, with rd_ptr, wr_ptr and a WBUF_AW+1-bit count.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo WBUF_DEPTH.
- host_ready is combinational:
  - state IDLE and host_we=1: ready = (count != WBUF_DEPTH), using the pre-pop count. When the buffer is full, a simultaneous pop does not free the slot until the next cycle.
  - state IDLE and host_we=0: ready = 1.
  - any other state: ready = 0.
- State machine (reset to IDLE):
  - IDLE → RD_PEND on an accepted read; host_addr is latched into rd_addr.
  - RD_PEND → RD_DATA in the cycle the read issues: !vga_req && count==0. Buffered writes always drain before the read, which guarantees read-after-write ordering.
  - RD_DATA → RD_RET unconditionally. host_rdata is captured from ram_q_b at the end of this cycle.
  - RD_RET → IDLE unconditionally. host_rvalid = 1 in this cycle only.
- Read latency:
  - Minimum is 3 cycles from acceptance to host_rvalid when the port is idle: issue in the cycle after acceptance, rvalid 2 cycles after issue.
  - Unbounded while vga_req stays high.
- Write acceptance: no writes are accepted outside IDLE, so none can enter between a read's acceptance and its return.
- VGA guarantee: vga_req is never delayed. vga_q = ram_q_b combinationally, so the VGA path sees its data exactly 1 cycle after vga_req, as it would on a private port.
- Reset (including mid-read or with a non-empty buffer):
  - buffer empties, pending read is dropped, state returns to IDLE.
  - host_rvalid = 0, host_rdata = 0.
  - no RAM write occurs in the reset cycle.

Optional Feature:
ARB_STARVE_STAT_EN.
- Defined: adds output port stat_starve [15:0], a saturating counter (stops at 16'hFFFF). It increments on every cycle where vga_req=1 and the host has work blocked by it (count!=0 or state==RD_PEND). Clears on reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Idle arbitration, host write: host write addr 16'h8000, data 16'h0123, vga_req=0 → host_ready=1; next cycle ram_we_b=1, ram_addr_b=16'h8000, ram_d_b=16'h0123.
2. VGA priority: 4 host writes to 16'h8000..16'h8003 while vga_req held high for 10 cycles → buffer fills, 5th write sees host_ready=0, ram_we_b stays 0 throughout; after vga_req drops, writes drain in order 8000..8003, one per cycle.
3. Read-after-write ordering: write 16'h8001=16'h0042, then immediately read 16'h8001 → read issues only after the drain; host_rvalid with host_rdata=16'h0042 exactly 2 cycles after issue.
4. VGA latency check: vga_req every cycle with incrementing vga_addr while host reads are pending → ram_addr_b tracks vga_addr every cycle, vga_q matches the RAM model 1 cycle later, no host issue until vga_req drops.
5. Reset mid-operation: assert reset for 1 cycle with 3 buffered writes and a read in RD_PEND → no RAM writes afterwards, host_rvalid never pulses, state IDLE, host_ready=1.
6. With ARB_STARVE_STAT_EN: 1 buffered write, vga_req high 20 cycles → stat_starve=20; after reset, stat_starve=0.

Source files
------------

// File: rtl/vga_ram_port_arbiter.sv
// rtl/vga_ram_port_arbiter.sv - RAM port B arbiter: VGA fetch priority, posted host writes, ordered host reads (optional ARB_STARVE_STAT_EN)
module vga_ram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int WBUF_DEPTH = 4,
    parameter int WBUF_AW    = 2
) (
    input  logic                  pix_clk,
    input  logic                  reset,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic [DATA_WIDTH-1:0] vga_q,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic                  ram_we_b,
    output logic [DATA_WIDTH-1:0] ram_d_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
`ifdef ARB_STARVE_STAT_EN
    ,
    output logic [15:0]           stat_starve
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_PEND,
        ST_RD_DATA,
        ST_RD_RET
    } state_t;

    localparam logic [WBUF_AW:0] WBUF_FULL = (WBUF_AW+1)'(WBUF_DEPTH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]   host_rdata_q, host_rdata_d;
    logic [ADDR_WIDTH-1:0]   wbuf_addr_q [WBUF_DEPTH];
    logic [ADDR_WIDTH-1:0]   wbuf_addr_d [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0]   wbuf_data_q [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0]   wbuf_data_d [WBUF_DEPTH];
    logic [WBUF_AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [WBUF_AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [WBUF_AW:0]        count_q, count_d;

    logic wbuf_empty;
    logic push;
    logic pop;
    logic rd_accept;
    logic issue;

    // VGA data comes straight from the RAM, exactly as on a private port
    assign vga_q       = ram_q_b;
    assign host_rvalid = (state_q == ST_RD_RET);
    assign host_rdata  = host_rdata_q;
    assign wbuf_empty  = (count_q == '0);
    assign push        = host_req && host_ready && host_we;
    assign rd_accept   = host_req && host_ready && !host_we;
    assign pop         = !reset && !vga_req && !wbuf_empty;
    assign issue       = !reset && !vga_req && wbuf_empty && (state_q == ST_RD_PEND);

    // Host handshake: only IDLE accepts; writes need a free slot by the pre-pop count
    always_comb begin
        host_ready = 1'b0;
        if (state_q == ST_IDLE) begin
            host_ready = host_we ? (count_q != WBUF_FULL) : 1'b1;
        end
    end

    // Port B grant mux: reset, VGA, buffered write, pending read, idle
    always_comb begin
        ram_addr_b = '0;
        ram_we_b   = 1'b0;
        ram_d_b    = '0;
        if (reset) begin
            ram_addr_b = '0;
        end else if (vga_req) begin
            ram_addr_b = vga_addr;
        end else if (!wbuf_empty) begin
            ram_addr_b = wbuf_addr_q[rd_ptr_q];
            ram_d_b    = wbuf_data_q[rd_ptr_q];
            ram_we_b   = 1'b1;
        end else if (state_q == ST_RD_PEND) begin
            ram_addr_b = rd_addr_q;
        end
    end

    // Write buffer: circular FIFO, push on accepted write, pop when granted
    always_comb begin
        wbuf_addr_d = wbuf_addr_q;
        wbuf_data_d = wbuf_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            wbuf_addr_d[wr_ptr_q] = host_addr;
            wbuf_data_d[wr_ptr_q] = host_wdata;
            wr_ptr_d              = wr_ptr_q + WBUF_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + WBUF_AW'(1);
        end
        count_d = count_q + (WBUF_AW+1)'(push) - (WBUF_AW+1)'(pop);
    end

    // Read FSM: latch address, wait for drain and free port, capture, return
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        host_rdata_d = host_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_accept) begin
                    state_d   = ST_RD_PEND;
                    rd_addr_d = host_addr;
                end
            end
            ST_RD_PEND: begin
                if (issue) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                state_d      = ST_RD_RET;
                host_rdata_d = ram_q_b;
            end
            ST_RD_RET: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers; reset drops buffered writes and any pending read
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            host_rdata_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            host_rdata_q <= host_rdata_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Buffer payload storage; contents are meaningless while count is zero
    always_ff @(posedge pix_clk) begin
        wbuf_addr_q <= wbuf_addr_d;
        wbuf_data_q <= wbuf_data_d;
    end

`ifdef ARB_STARVE_STAT_EN
    logic [15:0] stat_starve_q, stat_starve_d;

    assign stat_starve = stat_starve_q;

    // Count cycles where VGA holds the port while host work waits; saturates
    always_comb begin
        stat_starve_d = stat_starve_q;
        if (vga_req && (!wbuf_empty || state_q == ST_RD_PEND) && stat_starve_q != 16'hFFFF) begin
            stat_starve_d = stat_starve_q + 16'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            stat_starve_q <= '0;
        end else begin
            stat_starve_q <= stat_starve_d;
        end
    end
`endif

endmodule
